// File: rtl/fc_layer_param.sv
// Fully-connected layer engine: y = act(W*x) with runtime-loaded weights,
// P saturating MAC lanes sharing one x buffer, and valid/ready streams.

module fc_lane #(
  parameter int T  = 20,
  parameter int F  = 0,
  parameter int D  = 36,
  parameter int AW = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 w_we,
  input  logic [AW-1:0]        w_addr,
  input  logic signed [T-1:0]  w_data,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  input  logic signed [T-1:0]  x_rd,
  input  logic                 prd_en,
  input  logic                 acc_clr,
  input  logic                 acc_en,
  output logic signed [T-1:0]  acc_o
);
  localparam logic signed [T-1:0] SMAX = {1'b0, {(T-1){1'b1}}};
  localparam logic signed [T-1:0] SMIN = {1'b1, {(T-1){1'b0}}};

  logic signed [T-1:0]   wmem [D];
  logic signed [T-1:0]   w_rd_q, prd_q, prd_d, acc_q, acc_d, sum;
  logic signed [2*T-1:0] xe, we, prod, sh;

  always_ff @(posedge clk) begin
    if (w_we)  wmem[w_addr] <= w_data;
    if (rd_en) w_rd_q <= wmem[rd_addr];
  end

  assign xe   = {{T{x_rd[T-1]}}, x_rd};
  assign we   = {{T{w_rd_q[T-1]}}, w_rd_q};
  assign prod = xe * we;
  assign sh   = prod >>> F;
  assign sum  = acc_q + prd_q;

  // Product saturates when the bits above the result sign disagree with it.
  always_comb begin
    prd_d = sh[T-1:0];
    if (!(&sh[2*T-1:T-1]) && (|sh[2*T-1:T-1]))
      prd_d = sh[2*T-1] ? SMIN : SMAX;
    acc_d = sum;
    if ((acc_q[T-1] == prd_q[T-1]) && (sum[T-1] != acc_q[T-1]))
      acc_d = acc_q[T-1] ? SMIN : SMAX;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prd_q <= '0;
      acc_q <= '0;
    end else begin
      if (prd_en) prd_q <= prd_d;
      if (acc_clr)     acc_q <= '0;
      else if (acc_en) acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;
endmodule

module fc_layer_param #(
  parameter int M = 6,
  parameter int N = 6,
  parameter int T = 20,
  parameter int P = 1,
  parameter int R = 1,
  parameter int F = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic signed [T-1:0] w_data,
  input  logic                w_reload,
  input  logic                input_valid,
  output logic                input_ready,
  input  logic signed [T-1:0] input_data,
  output logic                output_valid,
  input  logic                output_ready,
  output logic signed [T-1:0] output_data
);
  localparam int G  = M / P;
  localparam int WD = (G * N > 1) ? G * N : 2;
  localparam int AW = $clog2(WD);
  localparam int XD = (N > 1) ? N : 2;
  localparam int NW = $clog2(XD);
  localparam int CW = $clog2(N + 2);
  localparam int LW = (P > 1) ? $clog2(P) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;

  typedef enum logic [2:0] {S_RST, S_LOAD_W, S_LOAD_X, S_COMPUTE, S_OUTPUT} state_t;

  state_t         state_q, state_d;
  logic [NW-1:0]  col_q, col_d, xcnt_q, xcnt_d;
  logic [LW-1:0]  lane_q, lane_d, oidx_q, oidx_d;
  logic [AW-1:0]  wbase_q, wbase_d, rbase_q, rbase_d;
  logic [GW-1:0]  g_q, g_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [1:0]     vld_pipe_q;
  logic           w_acc, x_acc, issue, acc_clr;

  logic signed [T-1:0]       xmem [XD];
  logic signed [T-1:0]       xr_q, sel;
  logic [P-1:0][T-1:0]       acc_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RST;
      col_q      <= '0;
      xcnt_q     <= '0;
      lane_q     <= '0;
      oidx_q     <= '0;
      wbase_q    <= '0;
      rbase_q    <= '0;
      g_q        <= '0;
      cyc_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      xcnt_q     <= xcnt_d;
      lane_q     <= lane_d;
      oidx_q     <= oidx_d;
      wbase_q    <= wbase_d;
      rbase_q    <= rbase_d;
      g_q        <= g_d;
      cyc_q      <= cyc_d;
      vld_pipe_q <= {vld_pipe_q[0], issue};
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    xcnt_d       = xcnt_q;
    lane_d       = lane_q;
    oidx_d       = oidx_q;
    wbase_d      = wbase_q;
    rbase_d      = rbase_q;
    g_d          = g_q;
    cyc_d        = cyc_q;
    w_ready      = 1'b0;
    input_ready  = 1'b0;
    output_valid = 1'b0;
    w_acc        = 1'b0;
    x_acc        = 1'b0;
    issue        = 1'b0;
    acc_clr      = 1'b0;
    case (state_q)
      S_RST: begin
        state_d = S_LOAD_W;
        col_d   = '0;
        lane_d  = '0;
        wbase_d = '0;
      end
      // Row-major words walk column, then lane, then group.
      S_LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          w_acc = 1'b1;
          if (col_q == NW'(N - 1)) begin
            col_d = '0;
            if (lane_q == LW'(P - 1)) begin
              lane_d = '0;
              if (wbase_q == AW'((G - 1) * N)) begin
                wbase_d = '0;
                xcnt_d  = '0;
                state_d = S_LOAD_X;
              end else begin
                wbase_d = wbase_q + AW'(N);
              end
            end else begin
              lane_d = lane_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_LOAD_X: begin
        if (w_reload && (xcnt_q == '0)) begin
          state_d = S_LOAD_W;
          col_d   = '0;
          lane_d  = '0;
          wbase_d = '0;
        end else begin
          input_ready = 1'b1;
          if (input_valid) begin
            x_acc = 1'b1;
            if (xcnt_q == NW'(N - 1)) begin
              xcnt_d  = '0;
              g_d     = '0;
              rbase_d = '0;
              cyc_d   = '0;
              acc_clr = 1'b1;
              state_d = S_COMPUTE;
            end else begin
              xcnt_d = xcnt_q + 1'b1;
            end
          end
        end
      end
      // N reads issued, then two cycles drain the product/accumulate stages.
      S_COMPUTE: begin
        issue = (cyc_q < CW'(N));
        if (cyc_q == CW'(N + 1)) begin
          oidx_d  = '0;
          state_d = S_OUTPUT;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_OUTPUT: begin
        output_valid = 1'b1;
        if (output_ready) begin
          if (oidx_q == LW'(P - 1)) begin
            oidx_d = '0;
            if (g_q == GW'(G - 1)) begin
              xcnt_d  = '0;
              state_d = S_LOAD_X;
            end else begin
              g_d     = g_q + 1'b1;
              rbase_d = rbase_q + AW'(N);
              cyc_d   = '0;
              acc_clr = 1'b1;
              state_d = S_COMPUTE;
            end
          end else begin
            oidx_d = oidx_q + 1'b1;
          end
        end
      end
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (x_acc) xmem[xcnt_q] <= input_data;
    if (issue) xr_q <= xmem[NW'(cyc_q)];
  end

  for (genvar p = 0; p < P; p++) begin : g_lane
    fc_lane #(.T(T), .F(F), .D(WD), .AW(AW)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .w_we    (w_acc && (lane_q == LW'(p))),
      .w_addr  (wbase_q + AW'(col_q)),
      .w_data  (w_data),
      .rd_en   (issue),
      .rd_addr (rbase_q + AW'(cyc_q)),
      .x_rd    (xr_q),
      .prd_en  (vld_pipe_q[0]),
      .acc_clr (acc_clr),
      .acc_en  (vld_pipe_q[1]),
      .acc_o   (acc_w[p])
    );
  end

  always_comb begin
    sel = '0;
    for (int p = 0; p < P; p++)
      if (oidx_q == LW'(p)) sel = acc_w[p];
    output_data = '0;
    if (state_q == S_OUTPUT)
      output_data = ((R != 0) && sel[T-1]) ? '0 : sel;
  end
endmodule

// File: tb/tb_fc_layer_param.sv
// Directed bench for fc_layer_param: three configurations, scoreboard queues
// filled at stimulus time and drained by an output monitor.

module tb_fc_layer_param;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]        w_valid, w_reload, in_valid, out_ready;
  logic [2:0][15:0]  w_data, in_data;
  wire  [2:0]        w_ready, in_ready, out_valid;
  wire  [2:0][15:0]  out_data;

  int tests = 0;
  int fails = 0;

  logic [15:0] q0[$], q1[$], q2[$];

  int W_A [12] = '{1, 2, 3, -1, 0, 0, 0, 0, 5, 2, 2, 2};
  int W_B [12] = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1, 1};
  int W_S [12] = '{32767, 32767, 32767, -32767, -32767, -32767, 0, 0, 0, 0, 0, 0};

  fc_layer_param #(.M(4), .N(3), .T(16), .P(2), .R(1), .F(0)) dut_a (
    .clk(clk), .reset(rst_n),
    .w_valid(w_valid[0]), .w_ready(w_ready[0]), .w_data(w_data[0]), .w_reload(w_reload[0]),
    .input_valid(in_valid[0]), .input_ready(in_ready[0]), .input_data(in_data[0]),
    .output_valid(out_valid[0]), .output_ready(out_ready[0]), .output_data(out_data[0]));

  fc_layer_param #(.M(4), .N(3), .T(16), .P(2), .R(0), .F(0)) dut_b (
    .clk(clk), .reset(rst_n),
    .w_valid(w_valid[1]), .w_ready(w_ready[1]), .w_data(w_data[1]), .w_reload(w_reload[1]),
    .input_valid(in_valid[1]), .input_ready(in_ready[1]), .input_data(in_data[1]),
    .output_valid(out_valid[1]), .output_ready(out_ready[1]), .output_data(out_data[1]));

  fc_layer_param #(.M(1), .N(1), .T(16), .P(1), .R(0), .F(8)) dut_c (
    .clk(clk), .reset(rst_n),
    .w_valid(w_valid[2]), .w_ready(w_ready[2]), .w_data(w_data[2]), .w_reload(w_reload[2]),
    .input_valid(in_valid[2]), .input_ready(in_ready[2]), .input_data(in_data[2]),
    .output_valid(out_valid[2]), .output_ready(out_ready[2]), .output_data(out_data[2]));

  task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int qsize(int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(int d, int v);
    case (d)
      0:       q0.push_back(16'(v));
      1:       q1.push_back(16'(v));
      default: q2.push_back(16'(v));
    endcase
  endtask

  function automatic logic [15:0] pop(int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Each output transfer must match the oldest pending expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_n && out_valid[d] && out_ready[d]) begin
        chk($sformatf("sb_pending_dut%0d", d), 32'(qsize(d) != 0), 32'd1);
        if (qsize(d) != 0)
          chk($sformatf("sb_data_dut%0d", d), $signed(out_data[d]), $signed(pop(d)));
      end
    end
  end

  task automatic send_w(int d, int v);
    int k = 0;
    w_valid[d] = 1'b1;
    w_data[d]  = 16'(v);
    do begin @(negedge clk); k++; end while (!w_ready[d] && k < 50);
    chk("w_handshake", 32'(w_ready[d]), 32'd1);
    @(posedge clk); #1;
    w_valid[d] = 1'b0;
  endtask

  task automatic send_x(int d, int v);
    int k = 0;
    in_valid[d] = 1'b1;
    in_data[d]  = 16'(v);
    do begin @(negedge clk); k++; end while (!in_ready[d] && k < 200);
    chk("x_handshake", 32'(in_ready[d]), 32'd1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic load_w12(int d, input int w[12]);
    for (int i = 0; i < 12; i++) send_w(d, w[i]);
  endtask

  task automatic push4(int d, int a, int b, int c, int e);
    push(d, a); push(d, b); push(d, c); push(d, e);
  endtask

  task automatic send3(int d, int a, int b, int c);
    send_x(d, a); send_x(d, b); send_x(d, c);
  endtask

  task automatic drain(int d);
    int k = 0;
    do begin @(posedge clk); #1; k++; end while ((qsize(d) != 0 || out_valid[d]) && k < 300);
    chk($sformatf("drain_dut%0d", d), 32'(qsize(d)), 32'd0);
  endtask

  task automatic reload(int d);
    w_reload[d] = 1'b1;
    @(negedge clk);
    chk("reload_in_ready_low", 32'(in_ready[d]), 32'd0);
    @(posedge clk); #1;
    w_reload[d] = 1'b0;
    chk("reload_w_ready", 32'(w_ready[d]), 32'd1);
  endtask

  initial begin
    int lat, k;
    logic seen;
    w_valid = '0; w_reload = '0; in_valid = '0; out_ready = '1;
    w_data = '0; in_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({w_ready[0], in_ready[0], out_valid[0], out_data[0]}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("w_ready_after_reset", 32'(w_ready[0]), 32'd1);

    load_w12(0, W_A);
    load_w12(1, W_A);

    // Basic vector with first-output latency
    push4(0, 14, 0, 15, 12);
    send3(0, 1, 2, 3);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid[0] && lat < 20);
    chk("first_valid_latency", lat, 6);
    drain(0);

    push4(1, 14, -1, 15, 12);
    send3(1, 1, 2, 3);
    drain(1);

    // Back-pressure: hold the first word for 5 cycles
    out_ready[0] = 1'b0;
    push4(0, 14, 0, 15, 12);
    send3(0, 1, 2, 3);
    k = 0;
    while (!out_valid[0] && k < 30) begin @(posedge clk); #1; k++; end
    chk("stall_valid_rise", 32'(out_valid[0]), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid[0]), 32'd1);
      chk("stall_data", $signed(out_data[0]), 14);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    drain(0);

    push4(0, 2, 0, 0, 2);
    send3(0, 0, 1, 0);
    drain(0);

    // Saturation, entered through a reload
    reload(1);
    load_w12(1, W_S);
    push4(1, 32767, -32768, 0, 0);
    send3(1, 32767, 32767, 32767);
    drain(1);

    // Fractional shift
    send_w(2, 512);
    push(2, 512);
    send_x(2, 256);
    drain(2);
    reload(2);
    send_w(2, -512);
    push(2, -512);
    send_x(2, 256);
    drain(2);

    // Reload ignored once an x word has been taken
    push4(0, 14, 0, 15, 12);
    send_x(0, 1);
    w_reload[0] = 1'b1;
    send_x(0, 2);
    send_x(0, 3);
    w_reload[0] = 1'b0;
    drain(0);

    // Reset during COMPUTE
    send3(0, 1, 2, 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs", 32'({w_ready[0], in_ready[0], out_valid[0], out_data[0]}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rst_state_w_ready", 32'(w_ready[0]), 32'd0);
    @(posedge clk); #1;
    chk("w_ready_after_rerelease", 32'(w_ready[0]), 32'd1);
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (out_valid[0]) seen = 1'b1; end
    chk("no_output_before_reload", 32'(seen), 32'd0);
    @(posedge clk); #1;

    load_w12(0, W_B);
    push4(0, 6, 5, 4, 15);
    send3(0, 4, 5, 6);
    drain(0);

    reload(0);
    load_w12(0, W_A);
    push4(0, 14, 0, 15, 12);
    send3(0, 1, 2, 3);
    drain(0);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
